alu_issue_stage: RTL and testbench



---
 rtl/alu_defs.sv | 34 +++
 rtl/alu_fwd_mux.sv | 49 ++++
 rtl/alu_issue_stage.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// ---------------------------------------------------------------------------
// alu_defs
// Shared definitions for the ALU and its issue stage: function-code width,
// function-code values, and helpers that classify a function code as legal
// (implemented by the ALU) or as a shift.
// ---------------------------------------------------------------------------
package alu_defs;

  localparam int FUNC_W = 5;

  localparam logic [FUNC_W-1:0] FN_ADD  = 5'b01100;
  localparam logic [FUNC_W-1:0] FN_ADDF = 5'b01101;
  localparam logic [FUNC_W-1:0] FN_SUB  = 5'b01110;
  localparam logic [FUNC_W-1:0] FN_SUBF = 5'b01111;
  localparam logic [FUNC_W-1:0] FN_AND  = 5'b10000;
  localparam logic [FUNC_W-1:0] FN_OR   = 5'b10001;
  localparam logic [FUNC_W-1:0] FN_XOR  = 5'b10010;
  localparam logic [FUNC_W-1:0] FN_NAND = 5'b10011;
  localparam logic [FUNC_W-1:0] FN_NOR  = 5'b10100;
  localparam logic [FUNC_W-1:0] FN_XNOR = 5'b10101;
  localparam logic [FUNC_W-1:0] FN_SHR  = 5'b10110;
  localparam logic [FUNC_W-1:0] FN_ASHR = 5'b10111;
  localparam logic [FUNC_W-1:0] FN_SHL  = 5'b11000;

  // The flag variants (ADDF/SUBF) are deliberately not supported.
  function automatic logic fn_is_legal(input logic [FUNC_W-1:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || ((f >= FN_AND) && (f <= FN_SHL));
  endfunction

  function automatic logic fn_is_shift(input logic [FUNC_W-1:0] f);
    return (f == FN_SHR) || (f == FN_ASHR) || (f == FN_SHL);
  endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// ---------------------------------------------------------------------------
// alu_fwd_mux
// Forwarding priority mux for one source operand. Sources are checked
// youngest-first: ISS (live ALU output), then RES, then the writeback port,
// falling back to the register-file read. Register 0 always yields zero.
// Ports:
//   i_rs                source register index
//   i_iss_fwd/_rd       ISS entry may forward / its destination
//   i_alu_d             ALU output (result of the ISS entry)
//   i_res_fwd/_rd/_data RES entry may forward / destination / value
//   i_wb_valid/_rd/_data writeback commit this cycle
//   i_rf_rdata          register-file read data
//   o_data              selected operand
// ---------------------------------------------------------------------------
module alu_fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_iss_fwd,
  input  logic [REG_ADDR_W-1:0] i_iss_rd,
  input  logic [DATA_WIDTH-1:0] i_alu_d,
  input  logic                  i_res_fwd,
  input  logic [REG_ADDR_W-1:0] i_res_rd,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata,
  output logic [DATA_WIDTH-1:0] o_data
);

  // First match wins; youngest producer has priority.
  always_comb begin
    o_data = i_rf_rdata;
    if (i_rs == {REG_ADDR_W{1'b0}}) begin
      o_data = {DATA_WIDTH{1'b0}};
    end else if (i_iss_fwd && (i_iss_rd == i_rs)) begin
      o_data = i_alu_d;
    end else if (i_res_fwd && (i_res_rd == i_rs)) begin
      o_data = i_res_data;
    end else if (i_wb_valid && (i_wb_rd == i_rs)) begin
      o_data = i_wb_data;
    end else begin
      o_data = i_rf_rdata;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Two-stage wrapper around the external combinational ALU:
//   ISS (issue register, drives the ALU) -> ALU -> RES (result register).
// Ports:
//   i_clk, i_rst (async, active-high), i_flush (squash ISS and RES)
//   i_dec_*/o_dec_ready : decoded instruction, valid/ready
//   o_rf_raddr1/2, i_rf_rdata1/2 : same-cycle register-file read
//   i_wb_valid/_rd/_data : writeback commit, used for forwarding
//   o_alu_en/_func/_s1/_s2, i_alu_d : ALU interface
//   o_res_valid, i_res_ready, o_res_rd/_data/_illegal : result to writeback
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_dec_valid,
  output logic                  o_dec_ready,
  input  logic [FUNC_W-1:0]     i_dec_func,
  input  logic [REG_ADDR_W-1:0] i_dec_rs1,
  input  logic [REG_ADDR_W-1:0] i_dec_rs2,
  input  logic [REG_ADDR_W-1:0] i_dec_rd,
  input  logic                  i_dec_use_imm,
  input  logic [DATA_WIDTH-1:0] i_dec_imm,
  output logic [REG_ADDR_W-1:0] o_rf_raddr1,
  output logic [REG_ADDR_W-1:0] o_rf_raddr2,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata1,
  input  logic [DATA_WIDTH-1:0] i_rf_rdata2,
  input  logic                  i_wb_valid,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_alu_en,
  output logic [FUNC_W-1:0]     o_alu_func,
  output logic [DATA_WIDTH-1:0] o_alu_s1,
  output logic [DATA_WIDTH-1:0] o_alu_s2,
  input  logic [DATA_WIDTH-1:0] i_alu_d,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [REG_ADDR_W-1:0] o_res_rd,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_illegal
);

  logic                  r_iss_valid;
  logic                  r_iss_legal;
  logic [REG_ADDR_W-1:0] r_iss_rd;
  logic [FUNC_W-1:0]     r_alu_func;
  logic [DATA_WIDTH-1:0] r_alu_s1;
  logic [DATA_WIDTH-1:0] r_alu_s2;

  logic                  r_res_valid;
  logic                  r_res_illegal;
  logic [REG_ADDR_W-1:0] r_res_rd;
  logic [DATA_WIDTH-1:0] r_res_data;

  logic                  w_res_load;
  logic                  w_dec_ready;
  logic                  w_accept;
  logic                  w_dec_legal;
  logic                  w_iss_fwd;
  logic                  w_res_fwd;
  logic [DATA_WIDTH-1:0] w_fwd1;
  logic [DATA_WIDTH-1:0] w_fwd2;
  logic [DATA_WIDTH-1:0] w_s2;

  // res_ready feeds dec_ready combinationally so a draining RES lets ISS refill.
  assign w_res_load  = r_iss_valid & (~r_res_valid | i_res_ready);
  assign w_dec_ready = ~i_flush & (~r_iss_valid | w_res_load);
  assign w_accept    = i_dec_valid & w_dec_ready;
  assign w_dec_legal = fn_is_legal(i_dec_func);

  // Illegal entries produce no meaningful value, so they never forward.
  assign w_iss_fwd = r_iss_valid & r_iss_legal;
  assign w_res_fwd = r_res_valid & ~r_res_illegal;

  alu_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd1 (
    .i_rs(i_dec_rs1), .i_iss_fwd(w_iss_fwd), .i_iss_rd(r_iss_rd), .i_alu_d(i_alu_d),
    .i_res_fwd(w_res_fwd), .i_res_rd(r_res_rd), .i_res_data(r_res_data),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_rf_rdata(i_rf_rdata1), .o_data(w_fwd1)
  );

  alu_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd2 (
    .i_rs(i_dec_rs2), .i_iss_fwd(w_iss_fwd), .i_iss_rd(r_iss_rd), .i_alu_d(i_alu_d),
    .i_res_fwd(w_res_fwd), .i_res_rd(r_res_rd), .i_res_data(r_res_data),
    .i_wb_valid(i_wb_valid), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .i_rf_rdata(i_rf_rdata2), .o_data(w_fwd2)
  );

  // S2 selection: immediate bypasses forwarding; shifts keep only the shift amount.
  always_comb begin
    w_s2 = w_fwd2;
    if (i_dec_use_imm) begin
      w_s2 = i_dec_imm;
    end else begin
      w_s2 = w_fwd2;
    end
    if (fn_is_shift(i_dec_func)) begin
      w_s2 = {{(DATA_WIDTH-SHAMT_W){1'b0}}, w_s2[SHAMT_W-1:0]};
    end else begin
      w_s2 = w_s2;
    end
  end

  // Issue register: load on accept, empty when its entry moves to RES.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iss_valid <= 1'b0;
      r_iss_legal <= 1'b0;
      r_iss_rd    <= {REG_ADDR_W{1'b0}};
      r_alu_func  <= {FUNC_W{1'b0}};
      r_alu_s1    <= {DATA_WIDTH{1'b0}};
      r_alu_s2    <= {DATA_WIDTH{1'b0}};
    end else if (i_flush) begin
      r_iss_valid <= 1'b0;
    end else if (w_accept) begin
      r_iss_valid <= 1'b1;
      r_iss_legal <= w_dec_legal;
      r_iss_rd    <= i_dec_rd;
      r_alu_func  <= w_dec_legal ? i_dec_func : {FUNC_W{1'b0}};
      r_alu_s1    <= w_fwd1;
      r_alu_s2    <= w_s2;
    end else if (w_res_load) begin
      r_iss_valid <= 1'b0;
    end else begin
      r_iss_valid <= r_iss_valid;
    end
  end

  // Result register: capture ALU output, hold while writeback stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res_valid   <= 1'b0;
      r_res_illegal <= 1'b0;
      r_res_rd      <= {REG_ADDR_W{1'b0}};
      r_res_data    <= {DATA_WIDTH{1'b0}};
    end else if (i_flush) begin
      r_res_valid <= 1'b0;
    end else if (w_res_load) begin
      r_res_valid   <= 1'b1;
      r_res_illegal <= ~r_iss_legal;
      r_res_rd      <= r_iss_rd;
      r_res_data    <= r_iss_legal ? i_alu_d : {DATA_WIDTH{1'b0}};
    end else if (i_res_ready) begin
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= r_res_valid;
    end
  end

  assign o_dec_ready   = w_dec_ready;
  assign o_rf_raddr1   = i_dec_rs1;
  assign o_rf_raddr2   = i_dec_rs2;
  assign o_alu_en      = r_iss_valid;
  assign o_alu_func    = r_alu_func;
  assign o_alu_s1      = r_alu_s1;
  assign o_alu_s2      = r_alu_s2;
  assign o_res_valid   = r_res_valid;
  assign o_res_rd      = r_res_rd;
  assign o_res_data    = r_res_data;
  assign o_res_illegal = r_res_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench: models the register file and the ALU around the DUT,
// pushes the expected result of every accepted instruction into a queue and
// compares it when writeback takes the result.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
  import alu_defs::*;

  logic        clk, rst, flush;
  logic        dec_valid, dec_ready, dec_use_imm;
  logic [4:0]  dec_func, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imm;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        alu_en;
  logic [4:0]  alu_func;
  logic [31:0] alu_s1, alu_s2, alu_d;
  logic        res_valid, res_ready, res_illegal;
  logic [4:0]  res_rd;
  logic [31:0] res_data;

  logic [31:0] regs [32];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] alu_ref(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      FN_NAND: return ~(a & b);
      FN_NOR:  return ~(a | b);
      FN_XNOR: return ~(a ^ b);
      FN_SHR:  return a >> b[4:0];
      FN_ASHR: return $unsigned($signed(a) >>> b[4:0]);
      FN_SHL:  return a << b[4:0];
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  assign alu_d     = alu_ref(alu_func, alu_s1, alu_s2);

  alu_issue_stage dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_func(dec_func),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2), .i_dec_rd(dec_rd),
    .i_dec_use_imm(dec_use_imm), .i_dec_imm(dec_imm),
    .o_rf_raddr1(rf_raddr1), .o_rf_raddr2(rf_raddr2),
    .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_alu_en(alu_en), .o_alu_func(alu_func), .o_alu_s1(alu_s1), .o_alu_s2(alu_s2),
    .i_alu_d(alu_d),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_rd(res_rd),
    .o_res_data(res_data), .o_res_illegal(res_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a result is consumed when valid and ready coincide.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL res_unexpected observed=rd%0d/%h expected=none", res_rd, res_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("res_rd", {27'd0, res_rd}, {27'd0, mon_e.rd});
        chk("res_data", res_data, mon_e.data);
        chk("res_illegal", {31'd0, res_illegal}, {31'd0, mon_e.ill});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, wait (bounded) for acceptance, record its expected result.
  task automatic issue(input logic [4:0] f, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic ui, input logic [31:0] im,
                       input logic [31:0] ed, input logic ei);
    int n;
    dec_func = f; dec_rs1 = r1; dec_rs2 = r2; dec_rd = d;
    dec_use_imm = ui; dec_imm = im; dec_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!dec_ready && n < 20) begin
      @(posedge clk); #1; @(negedge clk);
      n++;
    end
    checks++;
    assert (dec_ready === 1'b1) else begin
      failures++;
      $error("FAIL accept_timeout observed=%b expected=1", dec_ready);
    end
    if (dec_ready === 1'b1) sb.push_back('{rd: d, data: ed, ill: ei});
    @(posedge clk); #1;
    dec_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dec_valid = 1'b0; dec_func = 5'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0; dec_use_imm = 1'b0; dec_imm = 32'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; res_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[0] = 32'hDEAD_BEEF;  // register 0 must never be read through
    regs[2] = 32'd5; regs[3] = 32'd7; regs[6] = 32'd33;
    regs[10] = 32'h8000_0000; regs[11] = 32'h0000_0024;

    #12;
    chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("rst_alu_func", {27'd0, alu_func}, 32'd0);
    chk("rst_alu_s1", alu_s1, 32'd0);
    chk("rst_alu_s2", alu_s2, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_illegal", {31'd0, res_illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back dependency through the ISS forward path.
    issue(FN_ADD, 5'd2, 5'd3, 5'd1, 1'b0, 32'd0, 32'd12, 1'b0);
    issue(FN_SUB, 5'd1, 5'd3, 5'd4, 1'b0, 32'd0, 32'd5, 1'b0);
    @(negedge clk);
    chk("b2b_fwd_s1", alu_s1, 32'd12);
    chk("b2b_first_valid", {31'd0, res_valid}, 32'd1);
    tick(); @(negedge clk);
    chk("b2b_second_valid", {31'd0, res_valid}, 32'd1);
    chk("b2b_second_data", res_data, 32'd5);
    tick(); tick();

    // Stall: RES holds, ISS fills, third instruction waits.
    res_ready = 1'b0;
    issue(FN_ADD, 5'd2, 5'd0, 5'd20, 1'b1, 32'd1, 32'd6, 1'b0);
    issue(FN_SUB, 5'd3, 5'd2, 5'd21, 1'b0, 32'd0, 32'd2, 1'b0);
    dec_func = FN_XOR; dec_rs1 = 5'd2; dec_rs2 = 5'd3; dec_rd = 5'd22;
    dec_use_imm = 1'b0; dec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_dec_ready", {31'd0, dec_ready}, 32'd0);
      chk("stall_hold_data", res_data, 32'd6);
      chk("stall_hold_rd", {27'd0, res_rd}, 32'd20);
      if (i < 2) tick();
    end
    tick();
    res_ready = 1'b1;
    issue(FN_XOR, 5'd2, 5'd3, 5'd22, 1'b0, 32'd0, 32'd2, 1'b0);
    tick(); tick(); tick();

    // Forward priority: RES (r1=4) beats writeback (r1=9); r0 reads zero.
    res_ready = 1'b0;
    issue(FN_ADD, 5'd0, 5'd0, 5'd1, 1'b1, 32'd4, 32'd4, 1'b0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
    issue(FN_ADD, 5'd1, 5'd0, 5'd7, 1'b0, 32'd0, 32'd4, 1'b0);
    @(negedge clk);
    chk("fwd_res_over_wb", alu_s1, 32'd4);
    chk("r0_zero", alu_s2, 32'd0);
    wb_valid = 1'b0;
    tick();
    res_ready = 1'b1;
    tick(); tick(); tick();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd100;
    issue(FN_ADD, 5'd3, 5'd0, 5'd9, 1'b0, 32'd0, 32'd100, 1'b0);
    wb_rd = 5'd0; wb_data = 32'd55;
    issue(FN_ADD, 5'd0, 5'd0, 5'd11, 1'b0, 32'd0, 32'd0, 1'b0);
    wb_valid = 1'b0;
    tick(); tick(); tick();

    // Shift amount masking.
    issue(FN_ASHR, 5'd10, 5'd11, 5'd12, 1'b0, 32'd0, 32'hF800_0000, 1'b0);
    @(negedge clk);
    chk("shift_mask_s2", alu_s2, 32'd4);
    tick(); tick(); tick();

    // Illegal entry: zero result, never forwarded from ISS or RES.
    issue(FN_ADDF, 5'd2, 5'd3, 5'd6, 1'b0, 32'd0, 32'd0, 1'b1);
    issue(FN_ADD, 5'd6, 5'd0, 5'd13, 1'b0, 32'd0, 32'd33, 1'b0);
    issue(FN_ADD, 5'd6, 5'd0, 5'd14, 1'b1, 32'd1, 32'd34, 1'b0);
    tick(); tick(); tick();
    issue(FN_SUBF, 5'd2, 5'd3, 5'd15, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("illegal_func_zero", {27'd0, alu_func}, 32'd0);
    chk("illegal_alu_en", {31'd0, alu_en}, 32'd1);
    tick(); tick(); tick();

    // Flush during a RES stall with decode still offering.
    res_ready = 1'b0;
    issue(FN_ADD, 5'd2, 5'd3, 5'd16, 1'b0, 32'd0, 32'd12, 1'b0);
    issue(FN_AND, 5'd2, 5'd3, 5'd17, 1'b0, 32'd0, 32'd5, 1'b0);
    dec_func = FN_OR; dec_rs1 = 5'd2; dec_rs2 = 5'd3; dec_rd = 5'd18; dec_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_dec_ready", {31'd0, dec_ready}, 32'd0);
    tick();
    flush = 1'b0; dec_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_res_valid", {31'd0, res_valid}, 32'd0);
    chk("flush_alu_en", {31'd0, alu_en}, 32'd0);
    tick(); @(negedge clk);
    chk("flush_no_accept", {31'd0, alu_en}, 32'd0);
    res_ready = 1'b1;
    tick();

    // Asynchronous reset mid-stream.
    issue(FN_OR, 5'd2, 5'd3, 5'd18, 1'b0, 32'd0, 32'd7, 1'b0);
    issue(FN_NOR, 5'd2, 5'd3, 5'd19, 1'b0, 32'd0, 32'hFFFF_FFF8, 1'b0);
    #6;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_alu_en", {31'd0, alu_en}, 32'd0);
    chk("arst_alu_s1", alu_s1, 32'd0);
    chk("arst_res_data", res_data, 32'd0);
    chk("arst_res_rd", {27'd0, res_rd}, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    issue(FN_SHL, 5'd2, 5'd0, 5'd19, 1'b1, 32'h0000_0023, 32'd40, 1'b0);
    tick(); tick(); tick();
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
